// File: rtl/ps2_poll_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_poll_sequencer_if
// Description : Signal bundle between the PS2 poll sequencer, the gamepad
//               pad lines and the register wrapper.
//               master : sequencer side (drives pad lines and results)
//               slave  : pad + register-wrapper side
//   enable        level, 1 = keep polling
//   ps2_data      DATA line from pad (already synchronised)
//   ps2_att       ATTENTION, active low
//   ps2_clk       PS2 clock, idle high
//   ps2_cmd       COMMAND, idle high
//   buttons       validated button word, pressed = 1
//   buttons_valid one-cycle pulse when buttons updates
//   frame_err     one-cycle pulse when a frame is rejected
//   busy          1 while ps2_att = 0
//   sticks        analog bytes 5..8 (zero unless PS2_ANALOG_EN)
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_poll_sequencer_if;
   logic        enable;
   logic        ps2_data;
   logic        ps2_att;
   logic        ps2_clk;
   logic        ps2_cmd;
   logic [15:0] buttons;
   logic        buttons_valid;
   logic        frame_err;
   logic        busy;
   logic [31:0] sticks;

   modport master (
      input  enable, ps2_data,
      output ps2_att, ps2_clk, ps2_cmd, buttons, buttons_valid,
             frame_err, busy, sticks
   );

   modport slave (
      output enable, ps2_data,
      input  ps2_att, ps2_clk, ps2_cmd, buttons, buttons_valid,
             frame_err, busy, sticks
   );
endinterface
`default_nettype wire

// File: rtl/ps2_poll_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ps2_poll_sequencer
// Description : Self-timed PlayStation-2 gamepad poll sequencer. Runs poll
//               frames (0x01, 0x42, 0x00...) back-to-back separated by a
//               programmable ATTENTION-high gap, checks the response header
//               and publishes a validated 16-bit button word.
// Ports       : PCLK     system clock, rising edge
//               PRESERN  synchronous active-high reset
//               bus      ps2_poll_sequencer_if.master (pad lines + results)
// Macro       : PS2_ANALOG_EN - 9-byte frames, analog sticks captured and
//               device ID 0x73 required. Undefined: 5-byte frames, sticks=0.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_poll_sequencer #(
   parameter int HALF_PERIOD = 500,
   parameter int SETUP_CYC   = 1000,
   parameter int GAP_CYC     = 1000,
   parameter int POLL_CYC    = 250000,
   parameter int CNT_W       = 24
) (
   input  wire logic             PCLK,
   input  wire logic             PRESERN,
   ps2_poll_sequencer_if.master  bus
);

`ifdef PS2_ANALOG_EN
   localparam int c_NB         = 9;
   localparam int c_FIRST_KEPT = 1;   // ID byte is checked
`else
   localparam int c_NB         = 5;
   localparam int c_FIRST_KEPT = 2;   // ID byte is ignored
`endif
   // Only response bytes from c_FIRST_KEPT on are retained; byte k sits at
   // bit (k - c_FIRST_KEPT)*8 of r_frame once the frame is complete.
   localparam int c_KEEP_BITS = (c_NB - c_FIRST_KEPT) * 8;
   localparam int c_B2_LSB    = (2 - c_FIRST_KEPT) * 8;

   localparam logic [CNT_W-1:0] c_SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] c_HALF_LAST  = CNT_W'(HALF_PERIOD - 1);
   localparam logic [CNT_W-1:0] c_GAP_LAST   = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] c_POLL_LAST  = CNT_W'(POLL_CYC - 1);
   localparam logic [3:0]       c_LAST_BYTE  = 4'(c_NB - 1);

   typedef enum logic [2:0] {
      IDLE, SETUP, BIT_LO, BIT_HI, GAP, DONE, WAIT
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
   logic [2:0]             r_bit, w_bit_nxt;
   logic [3:0]             r_byte, w_byte_nxt;
   logic [c_KEEP_BITS-1:0] r_frame;

   logic        r_att, r_clk, r_cmd, r_busy, r_valid, r_err;
   logic [15:0] r_buttons;
   logic        w_att_nxt, w_clk_nxt, w_cmd_nxt, w_enter_done, w_hdr_ok;
   logic [7:0]  w_cmd_byte;

   // ------------------------------------------------------------------------
   // Next-state logic. Line levels are derived from the *next* state and bit
   // so the registered lines line up exactly with the state they belong to.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      w_bit_nxt   = r_bit;
      w_byte_nxt  = r_byte;

      case (r_state)
         IDLE: begin
            w_cnt_nxt = '0;
            if (bus.enable) w_state_nxt = SETUP;
         end
         SETUP: begin
            if (r_cnt == c_SETUP_LAST) begin
               w_state_nxt = BIT_LO;
               w_cnt_nxt   = '0;
               w_bit_nxt   = '0;
               w_byte_nxt  = '0;
            end
         end
         BIT_LO: begin
            if (r_cnt == c_HALF_LAST) begin
               w_state_nxt = BIT_HI;
               w_cnt_nxt   = '0;
            end
         end
         BIT_HI: begin
            if (r_cnt == c_HALF_LAST) begin
               w_cnt_nxt = '0;
               if (r_bit != 3'd7) begin
                  w_state_nxt = BIT_LO;
                  w_bit_nxt   = r_bit + 3'd1;
               end else if (r_byte == c_LAST_BYTE) begin
                  w_state_nxt = DONE;
               end else begin
                  w_state_nxt = GAP;
                  w_bit_nxt   = '0;
                  w_byte_nxt  = r_byte + 4'd1;
               end
            end
         end
         GAP: begin
            if (r_cnt == c_GAP_LAST) begin
               w_state_nxt = BIT_LO;
               w_cnt_nxt   = '0;
            end
         end
         DONE: begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = '0;
         end
         WAIT: begin
            if (r_cnt == c_POLL_LAST) begin
               w_state_nxt = bus.enable ? SETUP : IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      w_cmd_byte = (w_byte_nxt == 4'd0) ? 8'h01 :
                   (w_byte_nxt == 4'd1) ? 8'h42 : 8'h00;

      w_att_nxt = ~(w_state_nxt inside {SETUP, BIT_LO, BIT_HI, GAP});
      w_clk_nxt = (w_state_nxt != BIT_LO);
      w_cmd_nxt = (w_state_nxt inside {BIT_LO, BIT_HI}) ? w_cmd_byte[w_bit_nxt]
                                                         : 1'b1;

      // Last data bit was captured at the start of the final BIT_HI, so the
      // frame is complete when the transition into DONE is decided.
      w_enter_done = (w_state_nxt == DONE);
`ifdef PS2_ANALOG_EN
      w_hdr_ok = (r_frame[c_B2_LSB +: 8] == 8'h5A) && (r_frame[7:0] == 8'h73);
`else
      w_hdr_ok = (r_frame[c_B2_LSB +: 8] == 8'h5A);
`endif
   end

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
`ifdef PS2_ANALOG_EN
   logic [31:0] r_sticks;
`endif

   always_ff @(posedge PCLK) begin
      if (PRESERN) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bit     <= '0;
         r_byte    <= '0;
         r_frame   <= '0;
         r_att     <= 1'b1;
         r_clk     <= 1'b1;
         r_cmd     <= 1'b1;
         r_busy    <= 1'b0;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
         r_buttons <= '0;
`ifdef PS2_ANALOG_EN
         r_sticks  <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_byte  <= w_byte_nxt;
         r_att   <= w_att_nxt;
         r_clk   <= w_clk_nxt;
         r_cmd   <= w_cmd_nxt;
         r_busy  <= ~w_att_nxt;

         // Sample DATA on the clock rise (first BIT_HI cycle), LSB first.
         if (r_state == BIT_HI && r_cnt == '0 && r_byte >= 4'(c_FIRST_KEPT))
            r_frame <= {bus.ps2_data, r_frame[c_KEEP_BITS-1:1]};

         r_valid <= w_enter_done & w_hdr_ok;
         r_err   <= w_enter_done & ~w_hdr_ok;
         if (w_enter_done && w_hdr_ok) begin
            // Pad reports pressed as 0; invert so pressed = 1.
            r_buttons <= ~r_frame[c_B2_LSB+8 +: 16];
`ifdef PS2_ANALOG_EN
            r_sticks  <= r_frame[c_B2_LSB+24 +: 32];
`endif
         end
      end
   end

   assign bus.ps2_att       = r_att;
   assign bus.ps2_clk       = r_clk;
   assign bus.ps2_cmd       = r_cmd;
   assign bus.busy          = r_busy;
   assign bus.buttons_valid = r_valid;
   assign bus.frame_err     = r_err;
   assign bus.buttons       = r_buttons;
`ifdef PS2_ANALOG_EN
   assign bus.sticks        = r_sticks;
`else
   assign bus.sticks        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_poll_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_poll_sequencer
// Description : Testbench for ps2_poll_sequencer. A pad model answers each
//               frame from a response table; a frame-level reference model
//               predicts timing, command stream, buttons/sticks and pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_poll_sequencer;
   localparam int HP = 2;
   localparam int SU = 4;
   localparam int GP = 3;
   localparam int PL = 10;
`ifdef PS2_ANALOG_EN
   localparam int NB = 9;
`else
   localparam int NB = 5;
`endif
   localparam int FRAME_LEN = SU + NB*16*HP + (NB-1)*GP;

   logic PCLK    = 1'b0;
   logic PRESERN = 1'b1;

   ps2_poll_sequencer_if bus();

   ps2_poll_sequencer #(
      .HALF_PERIOD (HP),
      .SETUP_CYC   (SU),
      .GAP_CYC     (GP),
      .POLL_CYC    (PL),
      .CNT_W       (24)
   ) dut (
      .PCLK    (PCLK),
      .PRESERN (PRESERN),
      .bus     (bus)
   );

   always #5 PCLK = ~PCLK;

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] cmd_of(input int k);
      return (k == 0) ? 8'h01 : ((k == 1) ? 8'h42 : 8'h00);
   endfunction

   // ------------------------------------------------------------------------
   // Pad model + frame-level reference model
   // ------------------------------------------------------------------------
   logic [7:0]  next_resp [9];
   logic [7:0]  cur_resp  [9];
   logic [71:0] cmd_bits;
   logic [7:0]  mon_cb;
   logic [15:0] exp_buttons;
   logic [31:0] exp_sticks;
   int  rise_cnt, since_rise, low_cnt, high_cnt;
   int  frames_done = 0;
   bit  frame_active, after_frame, prev_att, prev_clk, done_now, ok;

   always @(negedge PCLK) begin
      if (PRESERN) begin
         frame_active = 0; after_frame = 0;
         exp_buttons  = '0; exp_sticks = '0;
         prev_att = 1; prev_clk = 1;
         rise_cnt = 0; since_rise = 0; low_cnt = 0; high_cnt = 0;
         bus.ps2_data = 1'b1;
      end else begin
         done_now = 0;
         if (!bus.ps2_att && prev_att) begin
            if (after_frame) check_eq("poll_gap", high_cnt, 1 + PL);
            frame_active = 1;
            low_cnt = 0; rise_cnt = 0; since_rise = 0;
            cmd_bits = '0;
            cur_resp = next_resp;
         end
         if (!bus.ps2_att) begin
            low_cnt++;
            if (bus.ps2_clk && !prev_clk) begin
               if (rise_cnt < 72) cmd_bits[rise_cnt] = bus.ps2_cmd;
               check_eq("busy_in_frame", bus.busy, 1);
               rise_cnt++;
               since_rise = 0;
            end else begin
               since_rise++;
               if (!bus.ps2_clk && prev_clk && rise_cnt < NB*8)
                  bus.ps2_data = cur_resp[rise_cnt/8][rise_cnt%8];
            end
            if (bus.ps2_clk && rise_cnt > 0) begin
               if (since_rise < HP) begin
                  mon_cb = cmd_of((rise_cnt-1)/8);
                  check_eq("cmd_hold", bus.ps2_cmd, mon_cb[(rise_cnt-1)%8]);
               end else begin
                  check_eq("cmd_gap", bus.ps2_cmd, 1);
               end
            end
         end else if (!prev_att && frame_active) begin
            done_now = 1;
`ifdef PS2_ANALOG_EN
            ok = (cur_resp[2] == 8'h5A) && (cur_resp[1] == 8'h73);
`else
            ok = (cur_resp[2] == 8'h5A);
`endif
            if (ok) begin
               exp_buttons = ~{cur_resp[4], cur_resp[3]};
`ifdef PS2_ANALOG_EN
               exp_sticks  = {cur_resp[8], cur_resp[7], cur_resp[6], cur_resp[5]};
`endif
            end
            check_eq("att_low_len", low_cnt, FRAME_LEN);
            check_eq("clk_rises", rise_cnt, NB*8);
            for (int k = 0; k < NB; k++)
               check_eq("cmd_byte", cmd_bits[k*8 +: 8], cmd_of(k));
            check_eq("busy_done", bus.busy, 0);
            frame_active = 0; after_frame = 1; high_cnt = 0;
            frames_done++;
         end
         check_eq("valid_pulse", bus.buttons_valid, done_now && ok);
         check_eq("err_pulse", bus.frame_err, done_now && !ok);
         check_eq("buttons", bus.buttons, exp_buttons);
         check_eq("sticks", bus.sticks, exp_sticks);
         if (bus.ps2_att) begin
            high_cnt++;
            if (!bus.enable) after_frame = 0;
         end
         prev_att = bus.ps2_att;
         prev_clk = bus.ps2_clk;
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   task automatic wait_frames(input int target);
      int n = 0;
      while (frames_done < target && n < 4000) begin
         @(negedge PCLK); #1;
         n++;
      end
      check_eq("frame_timeout", 32'(frames_done >= target), 1);
   endtask

   task automatic gen_frame(input bit force_ok);
      for (int i = 0; i < 9; i++) next_resp[i] = 8'($urandom);
      if (force_ok || $urandom_range(3) != 0) next_resp[2] = 8'h5A;
`ifdef PS2_ANALOG_EN
      if (force_ok || $urandom_range(3) != 0) next_resp[1] = 8'h73;
`endif
   endtask

   task automatic check_lines_idle();
      check_eq("att_idle", bus.ps2_att, 1);
      check_eq("clk_idle", bus.ps2_clk, 1);
      check_eq("cmd_idle", bus.ps2_cmd, 1);
      check_eq("busy_idle", bus.busy, 0);
   endtask

   initial begin
      int nf = 0;
      int n;
      bit found;
      bus.enable = 1'b0;
      for (int i = 0; i < 9; i++) next_resp[i] = 8'h00;

      // Reset state
      repeat (3) @(negedge PCLK);
      check_lines_idle();
      check_eq("rst_buttons", bus.buttons, 0);
      check_eq("rst_valid", bus.buttons_valid, 0);
      check_eq("rst_err", bus.frame_err, 0);
      check_eq("rst_sticks", bus.sticks, 0);
      #1 PRESERN = 1'b0;

      // Directed good frame
`ifdef PS2_ANALOG_EN
      next_resp = '{8'hFF, 8'h73, 8'h5A, 8'hFF, 8'hFF, 8'h80, 8'h7F, 8'h10, 8'hEF};
`else
      next_resp = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
      bus.enable = 1'b1;
      nf++; wait_frames(nf);
`ifdef PS2_ANALOG_EN
      check_eq("dir_buttons", bus.buttons, 16'h0000);
      check_eq("dir_sticks", bus.sticks, 32'hEF107F80);
      check_eq("dir_valid", bus.buttons_valid, 1);
      // Wrong device ID rejects the frame
      next_resp[1] = 8'h41;
      nf++; wait_frames(nf);
      check_eq("id_err", bus.frame_err, 1);
      check_eq("id_hold", bus.buttons, 16'h0000);
      next_resp[1] = 8'h73;
`else
      check_eq("dir_buttons", bus.buttons, 16'h8001);
      check_eq("dir_valid", bus.buttons_valid, 1);
`endif

      // Bad header byte
      next_resp[2] = 8'h00;
      nf++; wait_frames(nf);
      check_eq("hdr_err", bus.frame_err, 1);
      check_eq("hdr_no_valid", bus.buttons_valid, 0);
`ifdef PS2_ANALOG_EN
      check_eq("hdr_hold", bus.buttons, 16'h0000);
`else
      check_eq("hdr_hold", bus.buttons, 16'h8001);
`endif

      // Randomized frames
      for (int f = 0; f < 12; f++) begin
         gen_frame(0);
         nf++; wait_frames(nf);
      end

      // Drop enable during byte 3: frame completes, then WAIT and IDLE
      gen_frame(1);
      found = 0; n = 0;
      while (!found && n < 4000) begin
         @(negedge PCLK); #1; n++;
         if (frame_active && rise_cnt >= 24 && rise_cnt < 32) found = 1;
      end
      check_eq("reach_byte3", found, 1);
      bus.enable = 1'b0;
      nf++; wait_frames(nf);
      repeat (40) begin
         @(negedge PCLK);
         check_lines_idle();
      end

      // Reset during bit 4 of byte 2
      gen_frame(1);
      bus.enable = 1'b1;
      found = 0; n = 0;
      while (!found && n < 4000) begin
         @(negedge PCLK); #1; n++;
         if (frame_active && rise_cnt == 20 && !bus.ps2_clk) found = 1;
      end
      check_eq("reach_byte2_bit4", found, 1);
      PRESERN = 1'b1;
      @(negedge PCLK);
      check_lines_idle();
      check_eq("midrst_buttons", bus.buttons, 0);
      check_eq("midrst_valid", bus.buttons_valid, 0);
      check_eq("midrst_sticks", bus.sticks, 0);
      #1 PRESERN = 1'b0;
      gen_frame(1);
      nf++; wait_frames(nf);
      check_eq("post_rst_valid", bus.buttons_valid, 1);

      repeat (5) @(negedge PCLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
